// File: rtl/delay.sv
// Fixed-latency delay line: DELAY_CYCLES+1 register stages, out taken from the last.
// No enable and no handshake; every stage shifts on every rising clk edge.
module delay #(
    parameter int DELAY_CYCLES = 3,
    parameter int WIDTH        = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    localparam int STAGES = DELAY_CYCLES + 1;

    logic [WIDTH-1:0] stage [STAGES];

    // Reset clears every stage so in-flight values can never resurface afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= in;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign out = stage[STAGES-1];

endmodule

// File: tb/tb_delay.sv
// Randomised bench for delay: an 8-bit/3-cycle instance and a 4-bit/0-cycle instance
// checked against an edge-indexed history of sampled inputs.
module tb_delay;

    localparam int D_A = 3;
    localparam int W_A = 8;
    localparam int D_B = 0;
    localparam int W_B = 4;
    localparam int MAX_EDGES = 2048;

    logic           clk;
    logic           reset;
    logic [W_A-1:0] in_a;
    logic [W_A-1:0] out_a;
    logic [W_B-1:0] in_b;
    logic [W_B-1:0] out_b;

    int checks;
    int failures;

    // Reference history: what each edge sampled and the most recent reset edge.
    int             edge_cnt;
    int             last_rst;
    logic [W_A-1:0] hist_a [MAX_EDGES];
    logic [W_B-1:0] hist_b [MAX_EDGES];

    delay #(.DELAY_CYCLES(D_A), .WIDTH(W_A)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .in    (in_a),
        .out   (out_a)
    );

    delay #(.DELAY_CYCLES(D_B), .WIDTH(W_B)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .in    (in_b),
        .out   (out_b)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        edge_cnt = edge_cnt + 1;
        if (edge_cnt < MAX_EDGES) begin
            hist_a[edge_cnt] = in_a;
            hist_b[edge_cnt] = in_b;
        end
        if (reset) last_rst = edge_cnt;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s edge=%0d got=%0h expected=%0h", tag, edge_cnt, obs, exp);
        end
    endtask

    // Value sampled d edges ago, or zero if a reset edge lies in that window.
    function automatic logic [W_A-1:0] model_a(input int k);
        int src;
        src = k - D_A;
        if (src > last_rst && src >= 1) return hist_a[src];
        return '0;
    endfunction

    function automatic logic [W_B-1:0] model_b(input int k);
        int src;
        src = k - D_B;
        if (src > last_rst && src >= 1) return hist_b[src];
        return '0;
    endfunction

    // Driver: apply inputs mid-cycle, take one edge, compare at the falling edge.
    task automatic step(input logic rst, input logic [W_A-1:0] a, input logic [W_B-1:0] b);
        reset = rst;
        in_a  = a;
        in_b  = b;
        @(posedge clk);
        @(negedge clk);
        check("out_a", 32'(out_a), 32'(model_a(edge_cnt)));
        check("out_b", 32'(out_b), 32'(model_b(edge_cnt)));
    endtask

    logic [W_B-1:0] tog;
    int             pulse_edge;

    initial begin
        checks   = 0;
        failures = 0;
        edge_cnt = 0;
        last_rst = 0;
        reset    = 1'b1;
        in_a     = '1;
        in_b     = '1;
        tog      = 4'h5;
        @(negedge clk);

        // Reset held with all-ones input: outputs must read zero throughout.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, '1, '1);
            check("rst_a_zero", 32'(out_a), 32'd0);
            check("rst_b_zero", 32'(out_b), 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, '0);
            check("post_rst_zero", 32'(out_a), 32'd0);
        end

        // Step response: zero after edges 1..3, one from edge 4 on.
        for (int i = 1; i <= 8; i++) begin
            tog = ~tog;
            step(1'b0, 8'h01, tog);
            check("step", 32'(out_a), (i >= 4) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, tog);

        // Single-cycle pulse: high only after edge N+3.
        step(1'b0, 8'h01, 4'h0);
        pulse_edge = edge_cnt;
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, 8'h00, 4'hF);
            check("pulse", 32'(out_a), (edge_cnt == pulse_edge + 3) ? 32'd1 : 32'd0);
        end

        // Incrementing pattern: no gaps, no duplicates.
        for (int i = 1; i <= 20; i++) begin
            tog = ~tog;
            step(1'b0, 8'(i), tog);
            if (i > D_A) check("pattern", 32'(out_a), 32'(i - D_A));
        end

        // Mid-stream reset for a single edge, then resume with a fresh pattern.
        step(1'b1, 8'hAA, 4'hA);
        check("mid_rst_a", 32'(out_a), 32'd0);
        check("mid_rst_b", 32'(out_b), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 8'(8'h40 + i), 4'(i));
            check("resume", 32'(out_a), (i > D_A) ? 32'(8'h40 + i - D_A) : 32'd0);
        end

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 29) == 0), 8'($urandom), 4'($urandom));
        end
        step(1'b0, 8'h00, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
